// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port instruction/data memory between instruction fetch
//   (if_*) and the memory-stage data access (dm_*). Only one bus transaction
//   is ever outstanding. Data accesses win arbitration unless fetch has been
//   waiting STARVE_MAX cycles.
//
// Handshake rules:
//   Requesters raise xx_req and hold it, with stable address and data, until
//   xx_done pulses for one cycle. In the done cycle xx_req still carries the
//   old request, so it is not eligible for arbitration. The bus accepts a
//   request in any cycle with mem_req && mem_ready. mem_* are held stable
//   until then. For a read, mem_rvalid/mem_rdata arrive at least one cycle
//   after acceptance.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   if_req/if_addr      fetch request and address
//   if_kill             flush of the current fetch; its data is discarded
//   if_rdata/if_done    fetched word and one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be   data request (store when dm_we=1)
//   dm_rdata/dm_done    load data and one-cycle completion pulse
//   mem_*               memory bus (request side, ready, read return)
//   stall_f/stall_m     combinational stall requests to the hazard unit
//   fsm_state           current FSM state (encoding below)
//   starve_count        fetch starvation counter
//
// Optional build macro ARB_PERF_EN adds perf_if_grants, perf_dm_grants and
// perf_conflicts (32-bit, wrapping) counters.
//
// fsm_state encoding: 0 IDLE, 1 IF_ADDR, 2 IF_DATA, 3 DM_ADDR, 4 DM_DATA.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               if_req,
  input  logic [AW-1:0]                      if_addr,
  input  logic                               if_kill,
  output logic [DW-1:0]                      if_rdata,
  output logic                               if_done,
  input  logic                               dm_req,
  input  logic                               dm_we,
  input  logic [AW-1:0]                      dm_addr,
  input  logic [DW-1:0]                      dm_wdata,
  input  logic [DW/8-1:0]                    dm_be,
  output logic [DW-1:0]                      dm_rdata,
  output logic                               dm_done,
  output logic                               mem_req,
  output logic                               mem_we,
  output logic [AW-1:0]                      mem_addr,
  output logic [DW-1:0]                      mem_wdata,
  output logic [DW/8-1:0]                    mem_be,
  input  logic                               mem_ready,
  input  logic                               mem_rvalid,
  input  logic [DW-1:0]                      mem_rdata,
  output logic                               stall_f,
  output logic                               stall_m,
`ifdef ARB_PERF_EN
  output logic [31:0]                        perf_if_grants,
  output logic [31:0]                        perf_dm_grants,
  output logic [31:0]                        perf_conflicts,
`endif
  output logic [2:0]                         fsm_state,
  output logic [$clog2(STARVE_MAX+1)-1:0]    starve_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_IF_ADDR = 3'd1;
  localparam logic [2:0] S_IF_DATA = 3'd2;
  localparam logic [2:0] S_DM_ADDR = 3'd3;
  localparam logic [2:0] S_DM_DATA = 3'd4;

  localparam int              SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [DW/8-1:0] BE_ALL     = '1;

  logic [2:0]    state;
  logic [SW-1:0] starve_cnt;
  logic          drop;        // current fetch was flushed; discard its data

  logic if_elig;
  logic dm_elig;
  logic grant_dm;
  logic grant_if;
  logic in_if;
  logic accept;

  always_comb begin
    if_elig  = if_req && !if_done;
    dm_elig  = dm_req && !dm_done;
    // Data wins unless fetch is also waiting and has hit the starvation limit.
    grant_dm = (state == S_IDLE) && dm_elig &&
               (!if_elig || (starve_cnt < STARVE_LIM));
    grant_if = (state == S_IDLE) && if_elig && !grant_dm;
    in_if    = (state == S_IF_ADDR) || (state == S_IF_DATA);
    accept   = mem_req && mem_ready;
  end

  assign stall_f      = if_elig;
  assign stall_m      = dm_elig;
  assign fsm_state    = state;
  assign starve_count = starve_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      starve_cnt <= '0;
      drop       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;

      // Starvation counter: entry to IF_ADDR takes precedence over counting.
      if (grant_if) begin
        starve_cnt <= '0;
      end else if (if_elig && !in_if && (starve_cnt < STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (grant_dm) begin
            state     <= S_DM_ADDR;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_be;
          end else if (grant_if) begin
            state    <= S_IF_ADDR;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            mem_be   <= BE_ALL;
          end
        end

        S_IF_ADDR: begin
          if (if_kill) drop <= 1'b1;
          if (accept) begin
            mem_req <= 1'b0;
            state   <= S_IF_DATA;
          end
        end

        S_IF_DATA: begin
          if (mem_rvalid) begin
            // A kill in the same cycle as the data also discards it.
            if (!drop && !if_kill) begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end
            drop  <= 1'b0;
            state <= S_IDLE;
          end else if (if_kill) begin
            drop <= 1'b1;
          end
        end

        S_DM_ADDR: begin
          if (accept) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              // Stores complete on acceptance; there is no read return.
              dm_done <= 1'b1;
              state   <= S_IDLE;
            end else begin
              state <= S_DM_DATA;
            end
          end
        end

        S_DM_DATA: begin
          if (mem_rvalid) begin
            dm_rdata <= mem_rdata;
            dm_done  <= 1'b1;
            state    <= S_IDLE;
          end
        end

        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
          drop    <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_grants <= '0;
      perf_dm_grants <= '0;
      perf_conflicts <= '0;
    end else begin
      if (grant_if) perf_if_grants <= perf_if_grants + 32'd1;
      if (grant_dm) perf_dm_grants <= perf_dm_grants + 32'd1;
      if ((state == S_IDLE) && if_elig && dm_elig)
        perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Bench for mem_port_arbiter: a small memory model answers bus requests
//   with configurable ready and read-return delays, and a scoreboard holds the
//   expected completion data for fetch and data accesses.
module tb_mem_port_arbiter;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_IF_ADDR = 3'd1;
  localparam logic [2:0] S_IF_DATA = 3'd2;
  localparam logic [2:0] S_DM_ADDR = 3'd3;
  localparam logic [2:0] S_DM_DATA = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_kill, if_done;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_done;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        stall_f, stall_m;
  logic [2:0]  fsm_state;
  logic [2:0]  starve_count;
`ifdef ARB_PERF_EN
  logic [31:0] perf_if_grants, perf_dm_grants, perf_conflicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_if_q[$];
  logic [31:0] exp_dm_q[$];
  logic [31:0] last_if = '0;
  logic [31:0] last_dm = '0;
  logic [31:0] mon_exp;

  // memory model controls and state
  int          ready_delay  = 0;
  int          rvalid_delay = 1;
  int          wait_cnt     = 0;
  int          rv_cnt       = 0;
  bit          acc          = 0;
  bit          acc_we       = 0;
  bit          pend         = 0;
  logic [31:0] acc_addr     = '0;
  logic [31:0] rd_addr      = '0;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m),
`ifdef ARB_PERF_EN
    .perf_if_grants(perf_if_grants), .perf_dm_grants(perf_dm_grants),
    .perf_conflicts(perf_conflicts),
`endif
    .fsm_state(fsm_state), .starve_count(starve_count)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_data(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return (a ^ 32'hC0DE_0000) + 32'h11;
  endfunction

  // ---------------- memory model ----------------
  always @(negedge clk) begin
    if (rst) begin
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      acc        = 0;
      pend       = 0;
      wait_cnt   = ready_delay;
    end else begin
      mem_rvalid = 1'b0;
      if (acc && !acc_we) begin
        pend    = 1;
        rv_cnt  = rvalid_delay - 1;
        rd_addr = acc_addr;
      end
      acc = 0;
      if (pend) begin
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = model_data(rd_addr);
          pend       = 0;
        end else begin
          rv_cnt--;
        end
      end
      if (!mem_req) begin
        mem_ready = 1'b0;
        wait_cnt  = ready_delay;
      end else if (wait_cnt == 0) begin
        mem_ready = 1'b1;
        acc       = 1;
        acc_we    = mem_we;
        acc_addr  = mem_addr;
      end else begin
        mem_ready = 1'b0;
        wait_cnt--;
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (if_done) begin
        n_checks++;
        if (exp_if_q.size() == 0) begin
          n_fail++;
          $display("FAIL if_unexpected: if_done=1 if_rdata=%h, required no fetch completion", if_rdata);
        end else begin
          mon_exp = exp_if_q.pop_front();
          if (if_rdata !== mon_exp) begin
            n_fail++;
            $display("FAIL if_rdata: got %h required %h", if_rdata, mon_exp);
          end
        end
      end
      if (dm_done) begin
        n_checks++;
        if (exp_dm_q.size() == 0) begin
          n_fail++;
          $display("FAIL dm_unexpected: dm_done=1 dm_rdata=%h, required no data completion", dm_rdata);
        end else begin
          mon_exp = exp_dm_q.pop_front();
          if (dm_rdata !== mon_exp) begin
            n_fail++;
            $display("FAIL dm_rdata: got %h required %h", dm_rdata, mon_exp);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_if(input logic [31:0] a);
    last_if = model_data(a);
    exp_if_q.push_back(last_if);
  endtask

  task automatic push_dm_load(input logic [31:0] a);
    last_dm = model_data(a);
    exp_dm_q.push_back(last_dm);
  endtask

  task automatic wait_if_done(input int max, output bit got);
    got = 0;
    for (int i = 0; i < max; i++) begin
      if (if_done) begin got = 1; break; end
      step();
    end
  endtask

  task automatic wait_dm_done(input int max, output bit got);
    got = 0;
    for (int i = 0; i < max; i++) begin
      if (dm_done) begin got = 1; break; end
      step();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h100; if_kill = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    step(); step();
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_bus: got req=%b we=%b addr=%h wdata=%h be=%h required all 0",
               mem_req, mem_we, mem_addr, mem_wdata, mem_be);
    end
    n_checks++;
    if ({if_done, dm_done, if_rdata, dm_rdata} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_resp: got if_done=%b dm_done=%b if_rdata=%h dm_rdata=%h required all 0",
               if_done, dm_done, if_rdata, dm_rdata);
    end
    n_checks++;
    if (fsm_state !== S_IDLE || starve_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got state=%0d starve=%0d required 0 0", fsm_state, starve_count);
    end
  endtask

  task automatic test_fetch_basic();
    rst = 1'b0;
    exp_if_q.push_back(32'h0050_0093);
    last_if = 32'h0050_0093;
    n_checks++;
    if (stall_f !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_c0: got %b required 1", stall_f); end
    step();
    n_checks++;
    if ({mem_req, mem_we, mem_addr, mem_be, stall_f} !== {1'b1, 1'b0, 32'h100, 4'hF, 1'b1}) begin
      n_fail++;
      $display("FAIL fetch_c1: got req=%b we=%b addr=%h be=%h stall_f=%b required 1 0 00000100 f 1",
               mem_req, mem_we, mem_addr, mem_be, stall_f);
    end
    step();
    n_checks++;
    if ({mem_req, fsm_state, stall_f} !== {1'b0, S_IF_DATA, 1'b1}) begin
      n_fail++;
      $display("FAIL fetch_c2: got req=%b state=%0d stall_f=%b required 0 2 1", mem_req, fsm_state, stall_f);
    end
    step();
    n_checks++;
    if ({if_done, if_rdata, stall_f} !== {1'b1, 32'h0050_0093, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_c3: got done=%b rdata=%h stall_f=%b required 1 00500093 0", if_done, if_rdata, stall_f);
    end
    if_req = 1'b0;
    step();
    n_checks++;
    if ({if_done, fsm_state} !== {1'b0, S_IDLE}) begin
      n_fail++;
      $display("FAIL fetch_c4: got done=%b state=%0d required 0 0", if_done, fsm_state);
    end
  endtask

  task automatic test_conflict();
    bit got;
    step();
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000; dm_be = 4'hF;
    push_if(32'h200);
    push_dm_load(32'h2000);
    step();
    n_checks++;
    if ({fsm_state, mem_addr, mem_we, starve_count} !== {S_DM_ADDR, 32'h2000, 1'b0, 3'd1}) begin
      n_fail++;
      $display("FAIL conflict_grant: got state=%0d addr=%h we=%b starve=%0d required 3 00002000 0 1",
               fsm_state, mem_addr, mem_we, starve_count);
    end
    wait_dm_done(20, got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL conflict_dm_done: got no dm_done required one within 20 cycles"); end
    dm_req = 1'b0;
    step();
    n_checks++;
    if ({fsm_state, mem_addr, starve_count} !== {S_IF_ADDR, 32'h200, 3'd0}) begin
      n_fail++;
      $display("FAIL conflict_fetch: got state=%0d addr=%h starve=%0d required 1 00000200 0",
               fsm_state, mem_addr, starve_count);
    end
    wait_if_done(20, got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL conflict_if_done: got no if_done required one within 20 cycles"); end
    if_req = 1'b0;
    step();
`ifdef ARB_PERF_EN
    n_checks++;
    if ({perf_conflicts, perf_if_grants, perf_dm_grants} !== {32'd1, 32'd2, 32'd1}) begin
      n_fail++;
      $display("FAIL perf_counts: got conflicts=%0d if=%0d dm=%0d required 1 2 1",
               perf_conflicts, perf_if_grants, perf_dm_grants);
    end
`endif
  endtask

  task automatic test_starve();
    bit got;
    bit ok = 1;
    ready_delay = 3;
    step();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h3000; dm_wdata = 32'h1111_1111; dm_be = 4'hF;
    if_req = 1'b1; if_addr = 32'h300;
    exp_dm_q.push_back(last_dm);
    push_if(32'h300);
    for (int c = 1; c <= 4; c++) begin
      step();
      if (fsm_state !== S_DM_ADDR || starve_count !== 3'(c)) ok = 0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL starve_count_up: got state=%0d starve=%0d at cycle 4, required 3 4 and count 1..4",
               fsm_state, starve_count);
    end
    ready_delay = 0;
    step();
    n_checks++;
    if ({dm_done, starve_count, fsm_state} !== {1'b1, 3'd4, S_IDLE}) begin
      n_fail++;
      $display("FAIL starve_sat: got dm_done=%b starve=%0d state=%0d required 1 4 0", dm_done, starve_count, fsm_state);
    end
    // back-to-back store presented in the done cycle
    dm_addr = 32'h3004; dm_wdata = 32'h2222_2222;
    exp_dm_q.push_back(last_dm);
    step();
    n_checks++;
    if ({fsm_state, starve_count, mem_addr} !== {S_IF_ADDR, 3'd0, 32'h300}) begin
      n_fail++;
      $display("FAIL starve_fetch_wins: got state=%0d starve=%0d addr=%h required 1 0 00000300",
               fsm_state, starve_count, mem_addr);
    end
    wait_if_done(20, got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL starve_if_done: got no if_done required one within 20 cycles"); end
    if_req = 1'b0;
    wait_dm_done(20, got);
    n_checks++;
    if (!got || mem_wdata !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL starve_store2: got done=%b wdata=%h required 1 22222222", got, mem_wdata);
    end
    dm_req = 1'b0;
    step();
  endtask

  task automatic test_store_wait();
    bit ok = 1;
    ready_delay = 3;
    step(); step();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h4000; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011;
    exp_dm_q.push_back(last_dm);
    for (int c = 1; c <= 4; c++) begin
      step();
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, dm_done} !==
          {1'b1, 1'b1, 32'h4000, 32'hDEAD_BEEF, 4'b0011, 1'b0}) ok = 0;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL store_hold: got req=%b we=%b addr=%h wdata=%h be=%b required 1 1 00004000 deadbeef 0011 held 4 cycles",
               mem_req, mem_we, mem_addr, mem_wdata, mem_be);
    end
    step();
    n_checks++;
    if ({dm_done, mem_req, fsm_state} !== {1'b1, 1'b0, S_IDLE}) begin
      n_fail++;
      $display("FAIL store_done: got done=%b req=%b state=%0d required 1 0 0", dm_done, mem_req, fsm_state);
    end
    dm_req = 1'b0;
    ready_delay = 0;
    step();
    n_checks++;
    if (dm_done !== 1'b0) begin n_fail++; $display("FAIL store_pulse: got dm_done=%b required 0", dm_done); end
  endtask

  task automatic test_kill();
    bit got;
    bit saw = 0;
    // kill while IDLE is ignored
    step();
    if_req = 1'b1; if_addr = 32'h500; if_kill = 1'b1;
    push_if(32'h500);
    step();
    if_kill = 1'b0;
    n_checks++;
    if (fsm_state !== S_IF_ADDR) begin n_fail++; $display("FAIL kill_idle: got state=%0d required 1", fsm_state); end
    wait_if_done(20, got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL kill_idle_done: got no if_done required one"); end
    if_req = 1'b0;
    // kill in IF_DATA, data returns two cycles later
    rvalid_delay = 3;
    step();
    if_req = 1'b1; if_addr = 32'h600;
    step(); step();
    n_checks++;
    if (fsm_state !== S_IF_DATA) begin n_fail++; $display("FAIL kill_setup: got state=%0d required 2", fsm_state); end
    if_kill = 1'b1;
    step();
    if_kill = 1'b0; if_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (if_done) saw = 1;
      step();
    end
    n_checks++;
    if ({saw, fsm_state, if_rdata} !== {1'b0, S_IDLE, last_if}) begin
      n_fail++;
      $display("FAIL kill_drop: got done_seen=%b state=%0d rdata=%h required 0 0 %h", saw, fsm_state, if_rdata, last_if);
    end
    // kill in the same cycle as rvalid
    rvalid_delay = 1;
    if_req = 1'b1; if_addr = 32'h700;
    step(); step();
    if_kill = 1'b1;
    step();
    if_kill = 1'b0; if_req = 1'b0;
    n_checks++;
    if ({if_done, fsm_state, if_rdata} !== {1'b0, S_IDLE, last_if}) begin
      n_fail++;
      $display("FAIL kill_same_cycle: got done=%b state=%0d rdata=%h required 0 0 %h", if_done, fsm_state, if_rdata, last_if);
    end
    // the next fetch completes normally
    step();
    if_req = 1'b1; if_addr = 32'h780;
    push_if(32'h780);
    step();
    wait_if_done(20, got);
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL kill_recover: got no if_done required one"); end
    if_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bit got;
    rvalid_delay = 4;
    step();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h6000; dm_be = 4'hF;
    push_dm_load(32'h6000);
    step(); step();
    n_checks++;
    if (fsm_state !== S_DM_DATA) begin n_fail++; $display("FAIL rstmid_setup: got state=%0d required 4", fsm_state); end
    step();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({fsm_state, dm_rdata, if_rdata, mem_addr, mem_be, mem_req, dm_done} !== 105'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: got state=%0d dm_rdata=%h if_rdata=%h addr=%h be=%h required all 0",
               fsm_state, dm_rdata, if_rdata, mem_addr, mem_be);
    end
    dm_req = 1'b0;
    exp_dm_q.delete();
    last_dm = '0; last_if = '0;
    step(); step();
    rst = 1'b0;
    rvalid_delay = 1;
    step();
    if_req = 1'b1; if_addr = 32'h800;
    push_if(32'h800);
    wait_if_done(20, got);
    n_checks++;
    if (!got || if_rdata !== model_data(32'h800)) begin
      n_fail++;
      $display("FAIL rstmid_fetch: got done=%b rdata=%h required 1 %h", got, if_rdata, model_data(32'h800));
    end
    if_req = 1'b0;
    step(); step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    test_reset();
    test_fetch_basic();
    test_conflict();
    test_starve();
    test_store_wait();
    test_kill();
    test_reset_mid();
    n_checks++;
    if (exp_if_q.size() != 0 || exp_dm_q.size() != 0) begin
      n_fail++;
      $display("FAIL queues_empty: got if=%0d dm=%0d pending required 0 0", exp_if_q.size(), exp_dm_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-port instruction/data memory between the fetch stage (F) and the data access in the memory stage (M).
- Sequences each memory transaction through a request/accept/read-return FSM.
- Drives stall requests back to the hazard/conflict logic.
- Data accesses have priority, with an anti-starvation counter protecting fetch; a fetch killed by a branch flush is completed on the bus and discarded.

Parameters:
- AW, 32, address width
- DW, 32, data width (byte enables are DW/8)
- STARVE_MAX, 4, consecutive fetch-wait cycles after which fetch wins the next arbitration; min 1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  AW  fetch address
- if_kill  in  1  flush of the current fetch (PCSrcE)
- if_rdata  out  DW  fetched word, valid with if_done
- if_done  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request; held until dm_done
- dm_we  in  1  1=store, 0=load
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_be  in  DW/8  byte enables
- dm_rdata  out  DW  load data, valid with dm_done
- dm_done  out  1  one-cycle data completion pulse
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  AW  bus address
- mem_wdata  out  DW  bus write data
- mem_be  out  DW/8  bus byte enables
- mem_ready  in  1  bus accepts request when mem_req&&mem_ready
- mem_rvalid  in  1  read data valid; earliest the cycle after accept
- mem_rdata  in  DW  read data
- stall_f  out  1  if_req && !if_done (combinational)
- stall_m  out  1  dm_req && !dm_done (combinational)

Behaviour:
- Reset state: FSM=IDLE; starve_cnt=0; drop=0; mem_req, mem_we, if_done, dm_done=0; mem_addr, mem_wdata, mem_be, if_rdata, dm_rdata=0.
- FSM states: IDLE, IF_ADDR, IF_DATA, DM_ADDR, DM_DATA. At most one transaction outstanding.
- Request eligibility in IDLE: a requester is eligible if its req is high and its done is low that cycle. A done cycle's req is the old request and is ignored.
- IDLE arbitration:
  - dm eligible and (fetch not eligible or starve_cnt<STARVE_MAX) -> DM_ADDR.
  - Else fetch eligible -> IF_ADDR.
  - The chosen request's addr/we/wdata/be are registered onto mem_* and mem_req is set. For fetch, mem_we=0 and mem_be=all ones.
- xx_ADDR: hold all mem_* stable until mem_ready.
  - On accept, mem_req drops next cycle.
  - Store: -> IDLE with dm_done=1.
  - Load or fetch: -> xx_DATA.
- xx_DATA: on mem_rvalid, register mem_rdata into if_rdata/dm_rdata, pulse the matching done the next cycle, -> IDLE.
- Minimum load/fetch latency: req seen at cycle 0 -> mem_req at 1 -> rvalid at 2 -> done at 3.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) each cycle fetch is eligible-or-waiting and the FSM is not in IF_*.
  - Clears on entry to IF_ADDR.
- if_kill:
  - In IDLE: ignored.
  - In IF_ADDR/IF_DATA: sets drop. The bus transaction completes normally, but if_done is suppressed and if_rdata is not updated.
  - drop clears on return to IDLE.
  - The killed request must not be re-granted: if_req is re-evaluated only after IDLE is reached.
- Simultaneous kill and rvalid in IF_DATA: the data is dropped.
- rvalid outside xx_DATA is ignored.
- Reset asserted mid-transaction: immediately returns to reset state. The in-flight bus transaction is abandoned, and the memory model is reset with the same rst.

Optional Feature:
- Macro ARB_PERF_EN.
- When defined, adds three outputs:
  - perf_if_grants[31:0]: increments on each IF_ADDR entry.
  - perf_dm_grants[31:0]: increments on each DM_ADDR entry.
  - perf_conflicts[31:0]: increments each IDLE cycle in which both requesters are eligible.
- All three reset to 0 and wrap at 2^32.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset with if_req=1 -> all outputs 0; after release, fetch of 0x100 with mem_ready=1 and rvalid next cycle, rdata=0x00500093 -> if_done at cycle 3 with if_rdata=0x00500093, stall_f high cycles 0-2.
- if_req and dm_req (load 0x2000) asserted together in IDLE, STARVE_MAX=4 -> DM_ADDR granted first, dm_done with dm_rdata; then fetch granted; perf_conflicts=1 if ARB_PERF_EN.
- dm_req held with back-to-back stores, if_req held high -> after 4 fetch-wait cycles fetch wins the next IDLE, starve_cnt resets to 0.
- Store 0xDEADBEEF, dm_be=4'b0011, mem_ready low 3 cycles -> mem_* stable for 3 cycles, dm_done one cycle after accept, no rvalid wait.
- if_kill pulsed during IF_DATA, rvalid arrives 2 cycles later -> no if_done, if_rdata unchanged, FSM back to IDLE.
- rst asserted during DM_DATA -> outputs zero asynchronously, FSM IDLE; after release a new fetch completes normally.
